// File: rtl/face_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and constants for the six-face cube scan controller.
//   state_t           : scan sequencer states
//   color_code_t      : one classified sticker colour code
//   STICKERS_PER_FACE : stickers captured per face
//   CENTER_IDX        : sticker index of the face centre (fixed colour per face)
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int CODE_BITS         = 3;
    localparam int STICKERS_PER_FACE = 9;
    localparam int CENTER_IDX        = 4;

    typedef logic [CODE_BITS-1:0] color_code_t;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_EXEC,
        DETECT,
        CENTERS,
        INIT,
        SAMPLE,
        CHECK,
        STORE,
        VERIFY,
        ALL_DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/face_scan_sequencer_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// One-cycle pulse when the CCD pixel counters move into (0,0) from any other
// position. Holding the counters at (0,0) produces no further pulses.
// Ports:
//   Clk, Reset : clock, asynchronous active-low reset
//   i_x, i_y   : pixel column / row counters
//   o_tick     : frame start pulse
// -----------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int CNT_W = 11
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] i_x,
    input  logic [CNT_W-1:0] i_y,
    output logic             o_tick
);

    logic w_zero;
    logic r_prev_zero;

    assign w_zero = (i_x == '0) && (i_y == '0);

    // Reset value 1: counters already sitting at (0,0) when reset releases
    // are not treated as a fresh frame start.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_prev_zero <= 1'b1;
        end else begin
            r_prev_zero <= w_zero;
        end
    end

    assign o_tick = w_zero & ~r_prev_zero;

endmodule

// File: rtl/face_scan_sequencer.sv
// -----------------------------------------------------------------------------
// face_scan_sequencer
// Top-level scan controller for the six-face cube capture. Walks each face
// through detect -> centres -> accumulator init -> colour sampling -> colour
// check -> store, one video frame at a time, and raises algstart once every
// face is in the sticker bank.
// Ports:
//   Clk, Reset          : clock, asynchronous active-low reset
//   Execute             : debounced button level; rising edge starts/advances
//   X_Cont, Y_Cont      : CCD pixel counters (frame timing)
//   CubeDetected        : cube corner found
//   gotCenters          : block centres valid
//   color_codes         : nine classified codes, sticker 0 in the LSBs
//   ds, gc, init, cs, cc: datapath enables (Moore-decoded from state)
//   face_idx            : face being scanned
//   cube_state          : sticker bank, face f sticker s at (f*9+s)*CODE_W
//   facedone            : pulse once a face has been written to the bank
//   algstart            : high while all faces are captured
//   scan_error          : high in the error state
// Build option:
//   SCAN_CONSISTENCY_CHECK_EN : after the last face, scan the bank one sticker
//   per cycle; every colour must appear nine times and the six centres must
//   differ, otherwise enter ERROR and restart the scan from face 0.
// -----------------------------------------------------------------------------
module face_scan_sequencer
    import scan_pkg::*;
#(
    parameter int NUM_FACES      = 6,
    parameter int SAMPLE_FRAMES  = 4,
    parameter int DETECT_TIMEOUT = 30,
    parameter int CODE_W         = CODE_BITS
) (
    input  logic                                        Clk,
    input  logic                                        Reset,
    input  logic                                        Execute,
    input  logic [10:0]                                 X_Cont,
    input  logic [10:0]                                 Y_Cont,
    input  logic                                        CubeDetected,
    input  logic                                        gotCenters,
    input  logic [STICKERS_PER_FACE*CODE_W-1:0]         color_codes,
    output logic                                        ds,
    output logic                                        gc,
    output logic                                        init,
    output logic                                        cs,
    output logic                                        cc,
    output logic [2:0]                                  face_idx,
    output logic [NUM_FACES*STICKERS_PER_FACE*CODE_W-1:0] cube_state,
    output logic                                        facedone,
    output logic                                        algstart,
    output logic                                        scan_error
);

    localparam int SLOT_W = STICKERS_PER_FACE * CODE_W;
    localparam int BANK_W = NUM_FACES * SLOT_W;
    localparam int FCNT_W = 8;

    state_t              r_state;
    logic [2:0]          r_face_idx;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic [BANK_W-1:0]   r_cube;
    logic                r_facedone;
    logic                r_exec_q;

    logic                w_frame_tick;
    logic                w_exec_rise;
    logic [FCNT_W-1:0]   w_cnt_next;
    logic                w_found;

    frame_tick_gen #(.CNT_W(11)) u_frame_tick (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_x    (X_Cont),
        .i_y    (Y_Cont),
        .o_tick (w_frame_tick)
    );

    assign w_exec_rise = Execute & ~r_exec_q;
    // Saturating frame counter increment.
    assign w_cnt_next  = (r_frame_cnt == '1) ? r_frame_cnt : r_frame_cnt + FCNT_W'(1);
    // DETECT and CENTERS share the timeout rule; only the qualifier differs.
    assign w_found     = (r_state == DETECT) ? CubeDetected : gotCenters;

`ifdef SCAN_CONSISTENCY_CHECK_EN
    localparam int NCODES = 1 << CODE_W;

    logic [5:0]        r_vidx;
    logic [3:0]        r_vsub;
    logic [5:0]        r_hist [NCODES];
    logic [NCODES-1:0] r_center_seen;
    logic              r_dup;
    logic              r_verify_fail;
    logic [CODE_W-1:0] w_code;
    logic              w_hist_ok;

    assign w_code = r_cube[r_vidx*CODE_W +: CODE_W];

    always_comb begin
        w_hist_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (r_hist[c] != 6'(STICKERS_PER_FACE)) w_hist_ok = 1'b0;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_face_idx  <= '0;
            r_frame_cnt <= '0;
            r_cube      <= '0;
            r_facedone  <= 1'b0;
            r_exec_q    <= 1'b0;
`ifdef SCAN_CONSISTENCY_CHECK_EN
            r_vidx        <= '0;
            r_vsub        <= '0;
            r_center_seen <= '0;
            r_dup         <= 1'b0;
            r_verify_fail <= 1'b0;
            for (int c = 0; c < NCODES; c++) r_hist[c] <= '0;
`endif
        end else begin
            r_exec_q   <= Execute;
            r_facedone <= 1'b0;
            unique case (r_state)
                IDLE, WAIT_EXEC: begin
                    if (w_exec_rise) begin
                        r_state     <= DETECT;
                        r_frame_cnt <= '0;
                        if (r_state == IDLE) r_face_idx <= '0;
                    end
                end
                DETECT, CENTERS: begin
                    if (w_frame_tick) begin
                        if (w_found) begin
                            r_state     <= (r_state == DETECT) ? CENTERS : INIT;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= w_cnt_next;
                            if (w_cnt_next == FCNT_W'(DETECT_TIMEOUT)) r_state <= ERROR;
                        end
                    end
                end
                INIT: begin
                    r_state     <= SAMPLE;
                    r_frame_cnt <= '0;
                end
                SAMPLE: begin
                    if (w_frame_tick) begin
                        if (w_cnt_next == FCNT_W'(SAMPLE_FRAMES)) begin
                            r_state     <= CHECK;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= w_cnt_next;
                        end
                    end
                end
                CHECK: begin
                    if (w_frame_tick) r_state <= STORE;
                end
                STORE: begin
                    for (int f = 0; f < NUM_FACES; f++) begin
                        if (r_face_idx == 3'(f)) r_cube[f*SLOT_W +: SLOT_W] <= color_codes;
                    end
                    r_facedone <= 1'b1;
                    if (r_face_idx == 3'(NUM_FACES-1)) begin
`ifdef SCAN_CONSISTENCY_CHECK_EN
                        r_state       <= VERIFY;
                        r_vidx        <= '0;
                        r_vsub        <= '0;
                        r_center_seen <= '0;
                        r_dup         <= 1'b0;
                        for (int c = 0; c < NCODES; c++) r_hist[c] <= '0;
`else
                        r_state <= ALL_DONE;
`endif
                    end else begin
                        r_face_idx <= r_face_idx + 3'd1;
                        r_state    <= WAIT_EXEC;
                    end
                end
`ifdef SCAN_CONSISTENCY_CHECK_EN
                VERIFY: begin
                    if (r_vidx != 6'(NUM_FACES*STICKERS_PER_FACE)) begin
                        r_hist[w_code] <= r_hist[w_code] + 6'd1;
                        if (r_vsub == 4'(CENTER_IDX)) begin
                            if (r_center_seen[w_code]) r_dup <= 1'b1;
                            r_center_seen[w_code] <= 1'b1;
                        end
                        r_vsub <= (r_vsub == 4'(STICKERS_PER_FACE-1)) ? 4'd0 : r_vsub + 4'd1;
                        r_vidx <= r_vidx + 6'd1;
                    end else if (w_hist_ok && !r_dup) begin
                        r_state <= ALL_DONE;
                    end else begin
                        r_state       <= ERROR;
                        r_verify_fail <= 1'b1;
                    end
                end
`endif
                ALL_DONE: begin
                    if (w_exec_rise) begin
                        r_cube      <= '0;
                        r_face_idx  <= '0;
                        r_frame_cnt <= '0;
                        r_state     <= DETECT;
                    end
                end
                ERROR: begin
                    if (w_exec_rise) begin
                        r_frame_cnt <= '0;
                        r_state     <= DETECT;
`ifdef SCAN_CONSISTENCY_CHECK_EN
                        // A failed bank check invalidates every face.
                        if (r_verify_fail) begin
                            r_verify_fail <= 1'b0;
                            r_face_idx    <= '0;
                            r_cube        <= '0;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ds         = (r_state == DETECT) || (r_state == CENTERS);
    assign gc         = (r_state == CENTERS) || (r_state == SAMPLE);
    assign init       = (r_state == INIT);
    assign cs         = (r_state == SAMPLE);
    assign cc         = (r_state == CHECK);
    assign face_idx   = r_face_idx;
    assign cube_state = r_cube;
    assign facedone   = r_facedone;
    assign algstart   = (r_state == ALL_DONE);
    assign scan_error = (r_state == ERROR);

endmodule

// File: tb/tb_face_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_face_scan_sequencer
// Randomised bench for face_scan_sequencer. A small frame generator drives the
// pixel counters; the reference keeps the expected sticker bank as an array of
// codes and derives frame counts per phase from the scan rules.
// -----------------------------------------------------------------------------
module tb_face_scan_sequencer;

    localparam int CODE_W = 3;
    localparam int NF     = 6;
    localparam int SF     = 4;
    localparam int DT     = 30;
    localparam int SLOT_W = 9 * CODE_W;
    localparam int BANK_W = NF * SLOT_W;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Execute = 1'b0;
    logic [10:0]       X_Cont = 11'd1;
    logic [10:0]       Y_Cont = 11'd0;
    logic              CubeDetected = 1'b0;
    logic              gotCenters = 1'b0;
    logic [SLOT_W-1:0] color_codes = '0;
    logic              ds, gc, init, cs, cc, facedone, algstart, scan_error;
    logic [2:0]        face_idx;
    logic [BANK_W-1:0] cube_state;

    face_scan_sequencer #(
        .NUM_FACES(NF), .SAMPLE_FRAMES(SF), .DETECT_TIMEOUT(DT), .CODE_W(CODE_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute), .X_Cont(X_Cont), .Y_Cont(Y_Cont),
        .CubeDetected(CubeDetected), .gotCenters(gotCenters), .color_codes(color_codes),
        .ds(ds), .gc(gc), .init(init), .cs(cs), .cc(cc), .face_idx(face_idx),
        .cube_state(cube_state), .facedone(facedone), .algstart(algstart),
        .scan_error(scan_error)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [BANK_W-1:0] got, input logic [BANK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: expected sticker codes and face index.
    int exp_code [54];
    int exp_face = 0;

    function automatic logic [BANK_W-1:0] exp_bank();
        logic [BANK_W-1:0] v = '0;
        for (int i = 0; i < 54; i++) v[i*CODE_W +: CODE_W] = CODE_W'(exp_code[i]);
        return v;
    endfunction

    // Frame generator and phase monitor. Frames are 4 x 3 pixels (12 cycles).
    bit frame_run = 0;
    bit hold_zero = 0;
    bit tb_tick   = 0;
    int n_det, n_cen, n_cs, n_cc, n_init, n_fd, n_ds_cyc;
    int det_t = 999;
    int cen_t = 999;

    initial begin : frame_driver
        bit was_zero;
        forever begin
            @(negedge Clk);
            was_zero = (X_Cont == 11'd0) && (Y_Cont == 11'd0);
            if (hold_zero) begin
                X_Cont = 11'd0;
                Y_Cont = 11'd0;
            end else if (frame_run) begin
                if (X_Cont >= 11'd3) begin
                    X_Cont = 11'd0;
                    Y_Cont = (Y_Cont >= 11'd2) ? 11'd0 : Y_Cont + 11'd1;
                end else begin
                    X_Cont = X_Cont + 11'd1;
                end
            end
            tb_tick = (X_Cont == 11'd0) && (Y_Cont == 11'd0) && !was_zero;
            CubeDetected = 1'b0;
            gotCenters   = 1'b0;
            if (Reset) begin
                if (ds) n_ds_cyc++;
                if (init) n_init++;
                if (facedone) n_fd++;
                if (tb_tick) begin
                    if (ds && !gc) begin n_det++; CubeDetected = (n_det >= det_t); end
                    if (ds && gc)  begin n_cen++; gotCenters   = (n_cen >= cen_t); end
                    if (cs) n_cs++;
                    if (cc) n_cc++;
                end
            end
        end
    end

    task automatic clear_counts();
        n_det = 0; n_cen = 0; n_cs = 0; n_cc = 0; n_init = 0; n_fd = 0;
    endtask

    task automatic exec_pulse();
        Execute = 1'b1;
        repeat (2) @(negedge Clk);
        Execute = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_cs(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (cs) begin ok = 1; break; end
        end
    endtask

    // Runs one face; dt/ct are the frame numbers at which the cube / centres
    // are reported (dt > DT means never, expecting a timeout).
    task automatic run_face(input int dt, input int ct, input bit disturb);
        logic [SLOT_W-1:0] codes;
        bit ok;
        int a, b, fi;
        fi = exp_face;
        for (int s = 0; s < 9; s++) codes[s*CODE_W +: CODE_W] = CODE_W'($urandom_range(0, 5));
        color_codes = codes;
        det_t = dt;
        cen_t = ct;
        clear_counts();
        exec_pulse();
        if (disturb) begin
            wait_cs(ok);
            chk("reach_sample", BANK_W'(ok), BANK_W'(1));
            exec_pulse();
            exec_pulse();
            hold_zero = 1;
            repeat (5) @(negedge Clk);
            a = n_cs;
            repeat (95) @(negedge Clk);
            b = n_cs;
            hold_zero = 0;
            chk("hold_single_tick", BANK_W'(b), BANK_W'(a));
            chk("hold_still_sample", BANK_W'(cs), BANK_W'(1));
            chk("hold_face_idx", BANK_W'(face_idx), BANK_W'(fi));
        end
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (facedone || scan_error) begin ok = 1; break; end
        end
        chk("face_finished", BANK_W'(ok), BANK_W'(1));
        if (dt > DT) begin
            chk("timeout_error", BANK_W'(scan_error), BANK_W'(1));
            @(negedge Clk);
            chk("timeout_frames", BANK_W'(n_det), BANK_W'(DT));
            chk("timeout_face_idx", BANK_W'(face_idx), BANK_W'(fi));
            chk("timeout_bank_kept", cube_state, exp_bank());
            chk("timeout_no_sample", BANK_W'(n_cs), BANK_W'(0));
        end else begin
            chk("face_no_error", BANK_W'(scan_error), BANK_W'(0));
            for (int s = 0; s < 9; s++) exp_code[fi*9+s] = int'(codes[s*CODE_W +: CODE_W]);
            @(negedge Clk);
            chk("detect_frames", BANK_W'(n_det), BANK_W'(dt));
            chk("center_frames", BANK_W'(n_cen), BANK_W'(ct));
            chk("init_pulses", BANK_W'(n_init), BANK_W'(1));
            chk("sample_frames", BANK_W'(n_cs), BANK_W'(SF));
            chk("check_frames", BANK_W'(n_cc), BANK_W'(1));
            chk("facedone_pulses", BANK_W'(n_fd), BANK_W'(1));
            chk("bank_contents", cube_state, exp_bank());
            if (fi == NF - 1) begin
                chk("last_face_idx", BANK_W'(face_idx), BANK_W'(fi));
                chk("algstart_set", BANK_W'(algstart), BANK_W'(1));
            end else begin
                exp_face = fi + 1;
                chk("next_face_idx", BANK_W'(face_idx), BANK_W'(exp_face));
                chk("algstart_clear", BANK_W'(algstart), BANK_W'(0));
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        for (int i = 0; i < 54; i++) exp_code[i] = 0;
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_enables", BANK_W'({ds, gc, init, cs, cc, facedone, algstart, scan_error}), BANK_W'(0));
        chk("reset_face_idx", BANK_W'(face_idx), BANK_W'(0));
        chk("reset_bank", cube_state, '0);
        Reset = 1'b1;
        frame_run = 1;
        n_ds_cyc = 0;
        repeat (40) @(negedge Clk);
        chk("idle_no_ds", BANK_W'(n_ds_cyc), BANK_W'(0));

        run_face(2, 1, 0);
        run_face(999, 1, 0);
        run_face($urandom_range(1, 4), $urandom_range(1, 3), 1);
        for (int f = 2; f < NF; f++) run_face($urandom_range(1, 4), $urandom_range(1, 3), 0);

        // Rescan from ALL_DONE clears the bank.
        det_t = 1;
        cen_t = 1;
        clear_counts();
        exec_pulse();
        for (int i = 0; i < 54; i++) exp_code[i] = 0;
        exp_face = 0;
        chk("rescan_bank_clear", cube_state, exp_bank());
        chk("rescan_face_idx", BANK_W'(face_idx), BANK_W'(exp_face));
        chk("rescan_algstart", BANK_W'(algstart), BANK_W'(0));
        chk("rescan_ds", BANK_W'(ds), BANK_W'(1));

        // Asynchronous reset in the middle of sampling.
        wait_cs(ok);
        chk("rescan_sample", BANK_W'(ok), BANK_W'(1));
        #2 Reset = 1'b0;
        #1;
        chk("midreset_enables", BANK_W'({ds, gc, init, cs, cc, facedone, algstart, scan_error}), BANK_W'(0));
        chk("midreset_face_idx", BANK_W'(face_idx), BANK_W'(0));
        chk("midreset_bank", cube_state, '0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        n_ds_cyc = 0;
        repeat (40) @(negedge Clk);
        chk("post_reset_no_ds", BANK_W'(n_ds_cyc), BANK_W'(0));
        chk("post_reset_error", BANK_W'(scan_error), BANK_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
